// File: rtl/wb_stage.sv
// Write-back stage of the 5-stage MIPS core: register-file commit, CP0 register set,
// and the single resolution point for exceptions, interrupts and eret.
module wb_stage #(
    parameter logic [31:0] EX_ENTRY        = 32'hBFC0_0380,
    parameter int unsigned MS_TO_WS_BUS_WD = 155
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    input  logic [5:0]                 hw_int,
    output logic [3:0]                 rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       ws_handle_ex,
    output logic [31:0]                ws_ex_target,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    logic                       ws_valid;
    logic                       ws_ready_go;
    logic [MS_TO_WS_BUS_WD-1:0] ws_bus;

    logic        bus_ex;
    logic [4:0]  bus_exccode;
    logic        bus_bd;
    logic [31:0] bus_badvaddr;
    logic        bus_eret;
    logic        bus_mtc0;
    logic [7:0]  bus_cp0_addr;
    logic [31:0] bus_cp0_wdata;
    logic        bus_res_from_cp0;
    logic [3:0]  bus_rf_we;
    logic [4:0]  bus_dest;
    logic [31:0] bus_result;
    logic [31:0] bus_pc;

    assign {bus_ex, bus_exccode, bus_bd, bus_badvaddr, bus_eret, bus_mtc0,
            bus_cp0_addr, bus_cp0_wdata, bus_res_from_cp0, bus_rf_we,
            bus_dest, bus_result, bus_pc} = ws_bus;

    // CP0 state
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exccode;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        count_tick;

    logic        int_req;
    logic        ws_ex;
    logic [4:0]  ex_code;
    logic        mtc0_we;
    logic        wr_status, wr_cause, wr_epc, wr_compare, wr_count;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] cp0_rdata;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            ws_bus   <= '0;
        end else begin
            if (ws_handle_ex) begin
                ws_valid <= 1'b0;
            end else if (ws_allowin) begin
                ws_valid <= ms_to_ws_valid;
            end
            if (ms_to_ws_valid && ws_allowin) begin
                ws_bus <= ms_to_ws_bus;
            end
        end
    end

    assign int_req      = status_ie && !status_exl &&
                          (|({cause_ip_hw, cause_ip_sw} & status_im));
    assign ws_ex        = ws_valid && (int_req || bus_ex);
    assign ex_code      = int_req ? 5'd0 : bus_exccode;
    assign ws_handle_ex = ws_ex || (ws_valid && bus_eret);

    assign mtc0_we    = ws_valid && !ws_ex && bus_mtc0;
    assign wr_status  = mtc0_we && (bus_cp0_addr == ADDR_STATUS);
    assign wr_cause   = mtc0_we && (bus_cp0_addr == ADDR_CAUSE);
    assign wr_epc     = mtc0_we && (bus_cp0_addr == ADDR_EPC);
    assign wr_compare = mtc0_we && (bus_cp0_addr == ADDR_COMPARE);
    assign wr_count   = mtc0_we && (bus_cp0_addr == ADDR_COUNT);

    assign status_rd = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                        1'b0, cause_exccode, 2'b0};

    always_comb begin
        cp0_rdata = '0;
        case (bus_cp0_addr)
            ADDR_STATUS:   cp0_rdata = status_rd;
            ADDR_CAUSE:    cp0_rdata = cause_rd;
            ADDR_EPC:      cp0_rdata = epc;
            ADDR_COMPARE:  cp0_rdata = compare;
            ADDR_COUNT:    cp0_rdata = count;
            ADDR_BADVADDR: cp0_rdata = badvaddr;
            default:       cp0_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im     <= '0;
            status_exl    <= 1'b0;
            status_ie     <= 1'b0;
            cause_bd      <= 1'b0;
            cause_ti      <= 1'b0;
            cause_ip_hw   <= '0;
            cause_ip_sw   <= '0;
            cause_exccode <= '0;
            epc           <= '0;
            badvaddr      <= '0;
            count         <= '0;
            compare       <= '0;
            count_tick    <= 1'b0;
        end else begin
            count_tick <= ~count_tick;
            if (wr_count) begin
                count <= bus_cp0_wdata;
            end else if (count_tick) begin
                count <= count + 32'd1;
            end

            if (wr_compare) begin
                compare <= bus_cp0_wdata;
            end
            // Compare write clears TI even when Count==Compare in the same cycle
            if (wr_compare) begin
                cause_ti <= 1'b0;
            end else if (count == compare) begin
                cause_ti <= 1'b1;
            end

            cause_ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};
            if (wr_cause) begin
                cause_ip_sw <= bus_cp0_wdata[9:8];
            end

            if (ws_ex) begin
                if (!status_exl) begin
                    epc      <= bus_bd ? bus_pc - 32'd4 : bus_pc;
                    cause_bd <= bus_bd;
                end
                cause_exccode <= ex_code;
                status_exl    <= 1'b1;
                if (ex_code == 5'd4 || ex_code == 5'd5) begin
                    badvaddr <= bus_badvaddr;
                end
            end else begin
                if (wr_status) begin
                    status_im  <= bus_cp0_wdata[15:8];
                    status_exl <= bus_cp0_wdata[1];
                    status_ie  <= bus_cp0_wdata[0];
                end
                if (wr_epc) begin
                    epc <= bus_cp0_wdata;
                end
                if (ws_valid && bus_eret) begin
                    status_exl <= 1'b0;
                end
            end
        end
    end

    assign rf_we        = (ws_valid && !ws_ex) ? bus_rf_we : '0;
    assign rf_waddr     = ws_valid ? bus_dest : '0;
    assign rf_wdata     = ws_valid ? (bus_res_from_cp0 ? cp0_rdata : bus_result) : '0;
    assign ws_ex_target = !ws_handle_ex ? '0 :
                          (bus_eret && !ws_ex) ? epc : EX_ENTRY;

    assign debug_wb_pc       = ws_valid ? bus_pc : '0;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table of instructions with expected commit results,
// plus hand sequences for timer interrupt and asynchronous reset.
module tb_wb_stage;

    localparam logic [31:0] EX_ENTRY = 32'hBFC0_0380;
    localparam logic [7:0]  A_BVA = 8'h40, A_CNT = 8'h48, A_CMP = 8'h58,
                            A_STS = 8'h60, A_CAU = 8'h68, A_EPC = 8'h70, A_BAD = 8'h79;

    logic         clk;
    logic         resetn;
    logic         ms_to_ws_valid;
    logic [154:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic [5:0]   hw_int;
    logic [3:0]   rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         ws_handle_ex;
    logic [31:0]  ws_ex_target;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    wb_stage #(.EX_ENTRY(EX_ENTRY), .MS_TO_WS_BUS_WD(155)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin), .hw_int(hw_int),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_handle_ex(ws_handle_ex), .ws_ex_target(ws_ex_target),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct packed {
        logic        ex;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] bva;
        logic        eret;
        logic        mtc0;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        rcp0;
        logic [3:0]  we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic        exp_hex;
        logic [31:0] exp_target;
    } vec_t;

    typedef struct packed {
        logic [3:0]  we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        hex;
        logic [31:0] target;
        logic [31:0] pc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t alu(input logic [4:0] d, input logic [31:0] r, input logic [31:0] pc);
        vec_t v = '0;
        v.we = 4'hF; v.dest = d; v.result = r; v.pc = pc;
        v.exp_we = 4'hF; v.exp_wdata = r;
        return v;
    endfunction

    function automatic vec_t mtc0(input logic [7:0] a, input logic [31:0] w, input logic [31:0] pc);
        vec_t v = '0;
        v.mtc0 = 1'b1; v.addr = a; v.wdata = w; v.pc = pc;
        return v;
    endfunction

    function automatic vec_t mfc0(input logic [7:0] a, input logic [4:0] d,
                                  input logic [31:0] expv, input logic [31:0] pc);
        vec_t v = '0;
        v.rcp0 = 1'b1; v.addr = a; v.we = 4'hF; v.dest = d; v.pc = pc;
        v.exp_we = 4'hF; v.exp_wdata = expv;
        return v;
    endfunction

    function automatic vec_t exc(input logic [4:0] c, input logic b, input logic [31:0] bva,
                                 input logic [31:0] pc);
        vec_t v = '0;
        v.ex = 1'b1; v.code = c; v.bd = b; v.bva = bva; v.pc = pc;
        v.we = 4'hF; v.dest = 5'd2; v.result = 32'hEEEE_0000;
        v.exp_we = 4'h0; v.exp_wdata = 32'hEEEE_0000;
        v.exp_hex = 1'b1; v.exp_target = EX_ENTRY;
        return v;
    endfunction

    function automatic vec_t eret(input logic [31:0] pc, input logic [31:0] tgt);
        vec_t v = '0;
        v.eret = 1'b1; v.pc = pc; v.exp_hex = 1'b1; v.exp_target = tgt;
        return v;
    endfunction

    task automatic issue(input vec_t v, input string tag);
        exp_t e;
        e.we = v.exp_we; e.waddr = v.dest; e.wdata = v.exp_wdata;
        e.hex = v.exp_hex; e.target = v.exp_target; e.pc = v.pc;
        sb.push_back(e);
        ms_to_ws_bus = {v.ex, v.code, v.bd, v.bva, v.eret, v.mtc0, v.addr, v.wdata,
                        v.rcp0, v.we, v.dest, v.result, v.pc};
        ms_to_ws_valid = 1'b1;
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        e = sb.pop_front();
        chk({tag, " rf_we"},     {28'b0, rf_we},    {28'b0, e.we});
        chk({tag, " rf_waddr"},  {27'b0, rf_waddr}, {27'b0, e.waddr});
        chk({tag, " rf_wdata"},  rf_wdata,          e.wdata);
        chk({tag, " handle_ex"}, {31'b0, ws_handle_ex}, {31'b0, e.hex});
        if (e.hex) chk({tag, " ex_target"}, ws_ex_target, e.target);
        chk({tag, " dbg_pc"},    debug_wb_pc,       e.pc);
        chk({tag, " dbg_wen"},   {28'b0, debug_wb_rf_wen},  {28'b0, e.we});
        chk({tag, " dbg_wnum"},  {27'b0, debug_wb_rf_wnum}, {27'b0, e.waddr});
        chk({tag, " dbg_wdata"}, debug_wb_rf_wdata, e.wdata);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rf_we"},     {28'b0, rf_we}, 32'h0);
        chk({tag, " rf_wdata"},  rf_wdata, 32'h0);
        chk({tag, " handle_ex"}, {31'b0, ws_handle_ex}, 32'h0);
        chk({tag, " ex_target"}, ws_ex_target, 32'h0);
        chk({tag, " dbg_pc"},    debug_wb_pc, 32'h0);
        chk({tag, " allowin"},   {31'b0, ws_allowin}, 32'h1);
    endtask

    initial begin
        resetn = 1'b0; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; hw_int = '0;

        // TI is sticky from reset (Count==Compare==0); park Compare far away first
        tbl.push_back(mtc0(A_CMP, 32'hFFFF_FFFF, 32'hBFC0_0000));
        tbl.push_back(alu(5'd5, 32'h1234_5678, 32'hBFC0_0100));
        tbl.push_back(exc(5'd8, 1'b1, 32'h0, 32'hBFC0_0204));
        tbl.push_back(mfc0(A_EPC, 5'd8, 32'hBFC0_0200, 32'hBFC0_0380));
        tbl.push_back(mfc0(A_CAU, 5'd9, 32'h8000_0020, 32'hBFC0_0384));
        tbl.push_back(mfc0(A_STS, 5'd10, 32'h0040_0002, 32'hBFC0_0388));
        tbl.push_back(mtc0(A_EPC, 32'hBFC0_0500, 32'hBFC0_038C));
        tbl.push_back(eret(32'hBFC0_0390, 32'hBFC0_0500));
        tbl.push_back(mfc0(A_STS, 5'd11, 32'h0040_0000, 32'hBFC0_0500));
        tbl.push_back(exc(5'd4, 1'b0, 32'h0000_0003, 32'hBFC0_0300));
        tbl.push_back(mfc0(A_BVA, 5'd12, 32'h0000_0003, 32'hBFC0_0380));
        tbl.push_back(mfc0(A_CAU, 5'd13, 32'h0000_0010, 32'hBFC0_0384));
        tbl.push_back(exc(5'd8, 1'b1, 32'h0000_0055, 32'hBFC0_0400));
        tbl.push_back(mfc0(A_BVA, 5'd14, 32'h0000_0003, 32'hBFC0_0380));
        tbl.push_back(mfc0(A_CAU, 5'd15, 32'h0000_0020, 32'hBFC0_0384));
        tbl.push_back(mfc0(A_EPC, 5'd16, 32'hBFC0_0300, 32'hBFC0_0388));
        tbl.push_back(mtc0(A_BAD, 32'hCAFE_F00D, 32'hBFC0_038C));
        tbl.push_back(mfc0(A_BAD, 5'd17, 32'h0000_0000, 32'hBFC0_0390));
        tbl.push_back(mtc0(A_BVA, 32'hFFFF_FFFF, 32'hBFC0_0394));
        tbl.push_back(mfc0(A_BVA, 5'd18, 32'h0000_0003, 32'hBFC0_0398));
        tbl.push_back(mtc0(A_CAU, 32'hFFFF_FFFF, 32'hBFC0_039C));
        tbl.push_back(mfc0(A_CAU, 5'd19, 32'h0000_0320, 32'hBFC0_03A0));
        tbl.push_back(mtc0(A_CAU, 32'h0000_0000, 32'hBFC0_03A4));
        tbl.push_back(mtc0(A_STS, 32'hFFFF_FFFF, 32'hBFC0_03A8));
        tbl.push_back(mfc0(A_STS, 5'd20, 32'h0040_FF03, 32'hBFC0_03AC));
        tbl.push_back(mtc0(A_STS, 32'h0000_0000, 32'hBFC0_03B0));
        tbl.push_back(mfc0(A_STS, 5'd21, 32'h0040_0000, 32'hBFC0_03B4));

        #2;
        chk_idle("reset");
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk_idle("post_reset");

        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i], $sformatf("vec%0d", i));
        end

        // Timer interrupt
        begin
            vec_t v;
            issue(mtc0(A_CNT, 32'h0, 32'hBFC0_0600), "t_cnt");
            issue(mtc0(A_CMP, 32'd10, 32'hBFC0_0604), "t_cmp");
            issue(mtc0(A_STS, 32'h0040_8001, 32'hBFC0_0608), "t_sts");
            issue(alu(5'd6, 32'h0000_0066, 32'hBFC0_060C), "t_early");
            repeat (40) @(posedge clk);
            #1;
            v = alu(5'd7, 32'h0000_0077, 32'hBFC0_0610);
            v.exp_we = 4'h0; v.exp_hex = 1'b1; v.exp_target = EX_ENTRY;
            issue(v, "t_int");
            issue(mfc0(A_CAU, 5'd22, 32'h4000_8000, 32'hBFC0_0380), "t_cause");
            issue(mfc0(A_STS, 5'd23, 32'h0040_8003, 32'hBFC0_0384), "t_status");
            issue(mtc0(A_CMP, 32'hFFFF_FFFF, 32'hBFC0_0388), "t_clr");
            issue(mfc0(A_CAU, 5'd24, 32'h0000_0000, 32'hBFC0_038C), "t_cause2");
        end

        // Asynchronous reset with an instruction sitting in the stage
        ms_to_ws_bus = {1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0,
                        1'b0, 4'hF, 5'd3, 32'hAAAA_5555, 32'hBFC0_0700};
        ms_to_ws_valid = 1'b1;
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        chk("rst_pre rf_we", {28'b0, rf_we}, 32'hF);
        #2 resetn = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid rf_waddr", {27'b0, rf_waddr}, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        issue(mfc0(A_STS, 5'd25, 32'h0040_0000, 32'hBFC0_0000), "r_status");
        issue(mfc0(A_EPC, 5'd26, 32'h0000_0000, 32'hBFC0_0004), "r_epc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
